// File: rtl/rot180_addr_gen.sv
// Frame-buffer address generator for 180-degree rotation: linear writes in raster
// order, reversed readout, with two banks handed off between the write and read sides.
module rot180_addr_gen #(
  parameter int H_ACT = 160,
  parameter int V_ACT = 120
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_vs,
  input  logic        i_de,
  input  logic [15:0] i_data,
  output logic        o_wr_en,
  output logic [14:0] o_wr_addr,
  output logic [9:0]  o_wr_x,
  output logic [15:0] o_wr_data,
  output logic        o_wr_bank,
  input  logic        i_rd_start,
  input  logic        i_rd_req,
  output logic        o_rd_en,
  output logic [14:0] o_rd_addr,
  output logic [9:0]  o_rd_x,
  output logic        o_rd_bank,
  output logic        o_rd_busy,
  output logic        o_frame_rdy,
  output logic        o_rd_done
);

  localparam int          N         = H_ACT * V_ACT;
  localparam logic [14:0] LAST_ADDR = 15'(N - 1);
  localparam logic [9:0]  LAST_COL  = 10'(H_ACT - 1);
  localparam logic [14:0] LAST_ROW  = 15'(V_ACT - 1);

  typedef enum logic [1:0] {IDLE, READ, DONE} rd_state_t;

  rd_state_t   state, state_nx;
  logic        vs_d;
  logic        wr_arm;
  logic [9:0]  wr_col;
  logic [14:0] wr_row;
  logic [14:0] wr_cnt;
  logic        commit_pend;
  logic        rdy_bank;
  logic [14:0] rd_cnt;
  logic [9:0]  rd_col;

  logic vs_rise, wr_accept, wr_last, overwrite, rd_go, rd_step;

  assign vs_rise   = i_vs & ~vs_d;
  // The sync cycle only re-arms; a pixel in that same cycle is not taken.
  assign wr_accept = wr_arm & i_de & ~vs_rise;
  assign wr_last   = (wr_col == LAST_COL) && (wr_row == LAST_ROW);
  assign overwrite = vs_rise & o_frame_rdy & (rdy_bank == o_wr_bank);
  assign rd_go     = (state == IDLE) & i_rd_start & o_frame_rdy & ~overwrite & ~commit_pend;
  assign rd_step   = (state == READ) & i_rd_req;

  // NOTE: reset is asynchronous; every register here is a plain flop, so all are cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // NOTE: state_nx gets its default first so no path through the case leaves it unassigned (no latch).
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (rd_go) state_nx = READ;
      READ:    if (rd_step && rd_cnt == LAST_ADDR) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d        <= 1'b0;
      wr_arm      <= 1'b0;
      wr_col      <= '0;
      wr_row      <= '0;
      wr_cnt      <= '0;
      commit_pend <= 1'b0;
      o_wr_en     <= 1'b0;
      o_wr_addr   <= '0;
      o_wr_x      <= '0;
      o_wr_data   <= '0;
    end else begin
      vs_d        <= i_vs;
      o_wr_en     <= wr_accept;
      commit_pend <= wr_accept & wr_last;
      if (vs_rise) begin
        wr_arm <= 1'b1;
        wr_col <= '0;
        wr_row <= '0;
        wr_cnt <= '0;
      end else if (wr_accept) begin
        o_wr_addr <= wr_cnt;
        o_wr_x    <= wr_col;
        o_wr_data <= i_data;
        if (wr_last) begin
          wr_arm <= 1'b0;
          wr_col <= '0;
          wr_row <= '0;
          wr_cnt <= '0;
        end else begin
          wr_cnt <= wr_cnt + 15'd1;
          if (wr_col == LAST_COL) begin
            wr_col <= '0;
            wr_row <= wr_row + 15'd1;
          end else begin
            wr_col <= wr_col + 10'd1;
          end
        end
      end
    end
  end

  // Bank hand-off: a commit while reading keeps the write bank, so the newer
  // frame replaces the pending one instead of landing on the bank being read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_bank    <= 1'b0;
      o_frame_rdy <= 1'b0;
      o_wr_bank   <= 1'b0;
      o_rd_bank   <= 1'b0;
    end else if (commit_pend) begin
      rdy_bank    <= o_wr_bank;
      o_frame_rdy <= 1'b1;
      if (!o_rd_busy) o_wr_bank <= ~o_wr_bank;
    end else if (rd_go) begin
      o_rd_bank   <= rdy_bank;
      o_frame_rdy <= 1'b0;
      if (rdy_bank == o_wr_bank) o_wr_bank <= ~o_wr_bank;
    end else if (overwrite) begin
      o_frame_rdy <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_rd_busy <= 1'b0;
      o_rd_done <= 1'b0;
      o_rd_en   <= 1'b0;
      o_rd_addr <= '0;
      o_rd_x    <= '0;
      rd_cnt    <= '0;
      rd_col    <= '0;
    end else begin
      o_rd_busy <= (state_nx != IDLE);
      o_rd_done <= (state_nx == DONE);
      o_rd_en   <= rd_step;
      if (rd_go) begin
        rd_cnt <= '0;
        rd_col <= '0;
      end else if (rd_step) begin
        o_rd_addr <= LAST_ADDR - rd_cnt;
        o_rd_x    <= LAST_COL - rd_col;
        rd_cnt    <= rd_cnt + 15'd1;
        rd_col    <= (rd_col == LAST_COL) ? 10'd0 : rd_col + 10'd1;
      end
    end
  end

endmodule

// File: doc/rot180_addr_gen.md
ROT180_ADDR_GEN -- requirements
Module: rot180_addr_gen

Interface
REQ-001 Parameters SHALL be: H_ACT, default 160, active pixels per line; V_ACT, default 120, active lines per frame. N = H_ACT*V_ACT, and N SHALL be at most 32768.
REQ-002 Ports SHALL be, one per line:
- clk  input  1  single clock; all logic on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- i_vs  input  1  frame sync, active-high; a rising edge marks frame start
- i_de  input  1  input pixel valid
- i_data  input  16  input pixel
- o_wr_en  output  1  frame-buffer write strobe
- o_wr_addr  output  15  linear write address
- o_wr_x  output  10  write column
- o_wr_data  output  16  registered i_data
- o_wr_bank  output  1  write bank select
- i_rd_start  input  1  one-cycle pulse: begin rotated readout
- i_rd_req  input  1  one-cycle pixel request from downstream
- o_rd_en  output  1  frame-buffer read strobe
- o_rd_addr  output  15  rotated read address
- o_rd_x  output  10  rotated output column
- o_rd_bank  output  1  read bank select
- o_rd_busy  output  1  readout in progress
- o_frame_rdy  output  1  complete frame available
- o_rd_done  output  1  one-cycle end-of-readout pulse

Function
REQ-003 Write side: i_vs SHALL be registered internally for edge detection. A rising edge SHALL clear the write column, row and linear counters to 0.
REQ-004 Write latency: each i_de=1 cycle with linear count < N SHALL assert o_wr_en for one cycle, 1 cycle later. The write outputs are: o_wr_addr = linear count; o_wr_x = column; o_wr_data = i_data.
REQ-005 Counter stepping: the column SHALL wrap from H_ACT-1 to 0 and increment the row. i_de pixels beyond count N-1 SHALL be ignored (o_wr_en stays 0) until the next i_vs rising edge.
REQ-006 Commit: when the pixel at address N-1 is written, rdy_bank SHALL take the current o_wr_bank and o_frame_rdy SHALL set, in the following cycle. o_wr_bank SHALL toggle at commit only if o_rd_busy=0; otherwise it is unchanged.
REQ-007 Incomplete frame: an i_vs rising edge before address N-1 is written SHALL discard the partial frame. No commit occurs and o_wr_bank is unchanged.
REQ-008 Overwrite: an i_vs rising edge while o_frame_rdy=1 and rdy_bank=o_wr_bank SHALL clear o_frame_rdy.
REQ-009 Read FSM SHALL have states IDLE, READ, DONE.
REQ-010 IDLE to READ: i_rd_start with registered o_frame_rdy=1 SHALL take the FSM to READ and SHALL:
- latch o_rd_bank = rdy_bank;
- clear o_frame_rdy;
- clear rd_cnt.
If rdy_bank = o_wr_bank at that moment, o_wr_bank SHALL toggle.
REQ-011 i_rd_start SHALL be ignored when o_frame_rdy=0, outside IDLE, or in the same cycle as an overwrite clear (REQ-008 wins).
REQ-012 A commit and i_rd_start in the same cycle SHALL NOT start readout; the start is ignored.
REQ-013 READ: each i_rd_req=1 cycle SHALL assert o_rd_en 1 cycle later, with:
- o_rd_addr = N-1-rd_cnt;
- o_rd_x = H_ACT-1-(rd_cnt mod H_ACT).
rd_cnt then increments.
REQ-014 After the N-th request the FSM SHALL enter DONE; DONE SHALL pulse o_rd_done for 1 cycle and return to IDLE. i_rd_req in IDLE or DONE SHALL be ignored.
REQ-015 o_rd_busy SHALL be 1 exactly in READ and DONE.
REQ-016 Invariant: while o_rd_busy=1, o_wr_bank SHALL differ from o_rd_bank.
REQ-017 All outputs SHALL be registered; arithmetic SHALL be unsigned, with no overflow beyond 15 bits for legal N.

Reset
REQ-018 While rst_n=0, all outputs, counters and the edge register SHALL be 0; the FSM SHALL be IDLE and rdy_bank 0. Reset SHALL apply immediately, without waiting for a clock.
REQ-019 Reset asserted mid-write or mid-read SHALL abandon the frame; no o_rd_done pulse SHALL be produced.
REQ-020 After release, the write side SHALL wait for an i_vs rising edge before accepting pixels.

Verification (H_ACT=4, V_ACT=2, N=8)
REQ-021 Write-then-read: i_vs edge, then 8 i_de cycles of data 0..7, then i_rd_start, then 8 i_rd_req cycles. Required:
- o_wr_addr 0..7 with o_wr_x 0,1,2,3,0,1,2,3;
- o_frame_rdy=1 with bank 0;
- o_rd_addr 7..0 with o_rd_x 3,2,1,0,3,2,1,0;
- o_rd_done pulses once.
REQ-022 Partial frame: 5 pixels, then a new i_vs edge -> o_frame_rdy stays 0, o_wr_bank stays 0, addresses restart at 0.
REQ-023 Busy commit: frame committed and readout of bank 0 in progress; next frame commits -> o_wr_bank stays 1 and o_frame_rdy=1. A further i_vs edge -> o_frame_rdy=0.
REQ-024 Start without a ready frame: i_rd_start with o_frame_rdy=0 -> FSM stays IDLE, o_rd_busy=0. Same-cycle commit and i_rd_start -> no readout.
REQ-025 Reset mid-read: rst_n low after 3 reads -> all outputs 0 immediately, no o_rd_done pulse; normal operation follows the next i_vs edge.
